// File: rtl/gfx_text_pkg.sv
// Shared constants and types for the text command sequencer: opcodes,
// default sweep geometry, sequencer states and a small opcode helper.
package gfx_text_pkg;

   localparam logic [7:0] OP_FLUSH = 8'd253;
   localparam logic [7:0] OP_CLEAR = 8'd254;

   localparam int COLS_DEF = 43;
   localparam int ROWS_DEF = 24;

   localparam int TIMEOUT_CYCLES = 2048;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_CLEAR      = 2'd1,
      ST_WAIT_FLUSH = 2'd2
   } seq_state_e;

   function automatic logic [7:0] opcodeOf(input logic [23:0] word);
      return word[23:16];
   endfunction

endpackage

// File: rtl/text_cmd_sequencer_if.sv
// Bus bundle between the CPU command port, the sequencer and the text buffer stage.
interface text_cmd_sequencer_if;

   logic [23:0] cpu_cmd;
   logic        cpu_valid;
   logic        cpu_ready;
   logic [23:0] cmd;
   logic        start;
   logic [5:0]  clearx;
   logic [4:0]  cleary;
   logic        flush_irq;
   logic        busy;
   logic        done_irq;

   modport slave (
      input  cpu_cmd, cpu_valid, flush_irq,
      output cpu_ready, cmd, start, clearx, cleary, busy, done_irq
   );

   modport master (
      output cpu_cmd, cpu_valid, flush_irq,
      input  cpu_ready, cmd, start, clearx, cleary, busy, done_irq
   );

endinterface

// File: rtl/text_cmd_fifo.sv
// Show-ahead command FIFO: head always presents the oldest word while not empty.
module text_cmd_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [AW:0]      count_q;

   assign head  = mem[rdPtr_q];
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);

   // Storage carries no reset; only the pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wrPtr_q] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/text_cmd_sequencer.sv
// Queues CPU text commands, forwards them, expands clear into a screen sweep and
// stalls on flush. Define TEXT_SEQ_TIMEOUT_EN to bound the flush wait at 2048 cycles.
module text_cmd_sequencer
   import gfx_text_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int COLS  = COLS_DEF,
   parameter int ROWS  = ROWS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   text_cmd_sequencer_if.slave  bus
);

   localparam logic [5:0] X_LAST = 6'(COLS - 1);
   localparam logic [4:0] Y_LAST = 5'(ROWS - 1);

   logic        fifoPush, fifoPop, fifoFull, fifoEmpty, consume;
   logic [23:0] fifoHead;
   logic [7:0]  stageOp;

   seq_state_e  state_q, state_d;
   logic        stageValid_q, stageValid_d;
   logic [23:0] stageWord_q, stageWord_d;
   logic [23:0] cmd_q, cmd_d;
   logic        start_q, start_d;
   logic [5:0]  clearX_q, clearX_d, xCnt_q, xCnt_d;
   logic [4:0]  clearY_q, clearY_d, yCnt_q, yCnt_d;
   logic        done_q, done_d;

   assign fifoPush = bus.cpu_valid && !fifoFull;

   text_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(24)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifoPush),
      .din   (bus.cpu_cmd),
      .pop   (fifoPop),
      .head  (fifoHead),
      .full  (fifoFull),
      .empty (fifoEmpty)
   );

   assign stageOp = opcodeOf(stageWord_q);

`ifdef TEXT_SEQ_TIMEOUT_EN
   localparam logic [10:0] TIMEOUT_LAST = 11'(TIMEOUT_CYCLES - 1);
   logic [10:0] waitCnt_q;
   logic        flushDone;

   assign flushDone = bus.flush_irq || (waitCnt_q == TIMEOUT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         waitCnt_q <= '0;
      end else if (state_q != ST_WAIT_FLUSH) begin
         waitCnt_q <= '0;
      end else begin
         waitCnt_q <= waitCnt_q + 11'd1;
      end
   end
`else
   logic flushDone;

   assign flushDone = bus.flush_irq;
`endif

   // The stage register sits between the FIFO head and the decoder, so a word needs
   // one edge to leave the FIFO and one more to be issued; it refills behind plain
   // words only, keeping clear/flush from pulling the next word early.
   always_comb begin
      state_d      = state_q;
      stageValid_d = stageValid_q;
      stageWord_d  = stageWord_q;
      cmd_d        = cmd_q;
      start_d      = 1'b0;
      clearX_d     = '0;
      clearY_d     = '0;
      done_d       = 1'b0;
      xCnt_d       = xCnt_q;
      yCnt_d       = yCnt_q;
      consume      = 1'b0;
      fifoPop      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (stageValid_q) begin
               consume = 1'b1;
               if (stageOp == OP_CLEAR) begin
                  state_d = ST_CLEAR;
               end else begin
                  cmd_d   = stageWord_q;
                  start_d = 1'b1;
                  if (stageOp == OP_FLUSH) begin
                     state_d = ST_WAIT_FLUSH;
                  end
               end
            end
         end
         ST_CLEAR: begin
            cmd_d    = {OP_CLEAR, 16'd0};
            start_d  = 1'b1;
            clearX_d = xCnt_q;
            clearY_d = yCnt_q;
            if (xCnt_q == X_LAST) begin
               xCnt_d = '0;
               if (yCnt_q == Y_LAST) begin
                  yCnt_d  = '0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  yCnt_d = yCnt_q + 5'd1;
               end
            end else begin
               xCnt_d = xCnt_q + 6'd1;
            end
         end
         ST_WAIT_FLUSH: begin
            if (flushDone) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      fifoPop = !fifoEmpty && (state_q == ST_IDLE) &&
                (!stageValid_q || (stageOp != OP_CLEAR && stageOp != OP_FLUSH));

      if (fifoPop) begin
         stageValid_d = 1'b1;
         stageWord_d  = fifoHead;
      end else if (consume) begin
         stageValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         stageValid_q <= 1'b0;
         stageWord_q  <= '0;
         cmd_q        <= '0;
         start_q      <= 1'b0;
         clearX_q     <= '0;
         clearY_q     <= '0;
         xCnt_q       <= '0;
         yCnt_q       <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         stageValid_q <= stageValid_d;
         stageWord_q  <= stageWord_d;
         cmd_q        <= cmd_d;
         start_q      <= start_d;
         clearX_q     <= clearX_d;
         clearY_q     <= clearY_d;
         xCnt_q       <= xCnt_d;
         yCnt_q       <= yCnt_d;
         done_q       <= done_d;
      end
   end

   assign bus.cpu_ready = !fifoFull;
   assign bus.cmd       = cmd_q;
   assign bus.start     = start_q;
   assign bus.clearx    = clearX_q;
   assign bus.cleary    = clearY_q;
   assign bus.done_irq  = done_q;
   assign bus.busy      = (state_q != ST_IDLE) || !fifoEmpty || stageValid_q;

endmodule

// File: doc/text_cmd_sequencer.md
TEXT_CMD_SEQUENCER -- requirements
Module: text_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, command FIFO depth (power of two, 2..64).
REQ-002 SHALL have parameter COLS, default 43, text columns swept per row.
REQ-003 SHALL have parameter ROWS, default 24, text rows swept.
REQ-004 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cpu_cmd  input  24  command word; [23:16] opcode, [15:0] operand.
REQ-007 SHALL have port cpu_valid  input  1  cpu_cmd offered this cycle.
REQ-008 SHALL have port cpu_ready  output  1  FIFO can accept a word; a word is taken when cpu_valid and cpu_ready are both high.
REQ-009 SHALL have port cmd  output  24  command to the text buffer stage.
REQ-010 SHALL have port start  output  1  cmd valid, single-cycle strobe per issued word.
REQ-011 SHALL have port clearx  output  6  clear column, valid with opcode-254 strobes.
REQ-012 SHALL have port cleary  output  5  clear row, valid with opcode-254 strobes.
REQ-013 SHALL have port flush_irq  input  1  text-buffer flush-complete pulse.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE, or while the FIFO is non-empty.
REQ-015 SHALL have port done_irq  output  1  one-cycle pulse when a clear sweep or flush completes.

Function
REQ-016 SHALL hold a DEPTH-entry FIFO with show-ahead head; cpu_ready = not full; push and pop in the same cycle leave the count unchanged.
REQ-017 SHALL implement states IDLE, CLEAR, WAIT_FLUSH.
REQ-018 SHALL, in IDLE with the FIFO non-empty, pop the head word each cycle (throughput 1 word/cycle).
REQ-019 SHALL register cmd/start, so a word pushed into an empty FIFO at edge E appears on cmd with start=1 after edge E+2.
REQ-020 SHALL, for opcode 254, pop the word without forwarding it and enter CLEAR.
REQ-021 SHALL, in CLEAR, emit one strobe per cycle with cmd={8'd254,16'd0} and clearx/cleary sweeping x 0..COLS-1 inner and y 0..ROWS-1 outer (COLS*ROWS strobes, 1032 at defaults).
REQ-022 SHALL, after the strobe at (COLS-1,ROWS-1), pulse done_irq one cycle, zero the counters and return to IDLE.
REQ-023 SHALL, for opcode 253, forward the word with start=1 and enter WAIT_FLUSH with no further pops.
REQ-024 SHALL leave WAIT_FLUSH to IDLE on the cycle after flush_irq=1, and pulse done_irq in that same cycle.
REQ-025 SHALL ignore flush_irq in IDLE and CLEAR.
REQ-026 SHALL forward every other opcode unchanged with start=1 and remain in IDLE.
REQ-027 SHALL drive clearx=0 and cleary=0 whenever start is low or cmd opcode is not 254.
REQ-028 SHALL keep accepting FIFO pushes in CLEAR and WAIT_FLUSH while not full.

Reset
REQ-029 SHALL, on rst, immediately force: state IDLE; FIFO empty; cmd=0; start=0; clearx=0; cleary=0; done_irq=0; busy=0; cpu_ready=1.
REQ-030 SHALL abandon any sweep or flush wait in progress on rst, with no done_irq.

Configuration
REQ-031 SHALL, with TEXT_SEQ_TIMEOUT_EN defined, count WAIT_FLUSH cycles; when the count reaches 2048 without flush_irq, return to IDLE and pulse done_irq.
REQ-032 SHALL, without TEXT_SEQ_TIMEOUT_EN, wait in WAIT_FLUSH indefinitely and contain no timeout counter.

Structure
REQ-033 SHALL take opcode constants (OP_FLUSH=253, OP_CLEAR=254), COLS/ROWS defaults and the state enum from package gfx_text_pkg.
REQ-034 SHALL place the FIFO in sub-module text_cmd_fifo (push, pop, head, full, empty).

Verification
REQ-035 SHALL cover: push 0x0A0010 into an empty FIFO at edge E -> cmd=0x0A0010, start=1 for exactly one cycle after edge E+2.
REQ-036 SHALL cover: push 0xFE0000 -> 1032 consecutive strobes, first (0,0), 44th (0,1), last (42,23); then one done_irq pulse.
REQ-037 SHALL cover: push 0xFD0000 then 0x0C0041 -> 0xFD0000 forwarded; 0x0C0041 withheld until flush_irq is pulsed 100 cycles later, then forwarded; done_irq pulses once.
REQ-038 SHALL cover: hold cpu_valid high during WAIT_FLUSH -> cpu_ready drops after 8 accepts; all 8 words are forwarded in order after flush_irq.
REQ-039 SHALL cover: assert rst at strobe 500 of a clear sweep -> all outputs 0 immediately; no done_irq; the next pushed word is forwarded normally.
REQ-040 SHALL cover, with TEXT_SEQ_TIMEOUT_EN: flush with no flush_irq -> done_irq pulses and state returns to IDLE 2048 cycles after entering WAIT_FLUSH.
